// File: rtl/imem_boot_ctrl.sv
// Boot sequencer for the 256-word instruction memory: loads a big-endian byte
// stream into memory, then releases the CPU and gates fetches beyond the program.
module imem_boot_ctrl #(
    parameter int DEPTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter int ADDR_LEN  = 32,
    parameter int INSTR_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 boot_start,
    input  logic [7:0]           ld_byte,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic                 ld_last,
    input  logic [ADDR_LEN-1:0]  cpu_pc,
    output logic [INSTR_LEN-1:0] cpu_inst,
    output logic                 cpu_run,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_waddr,
    output logic [INSTR_LEN-1:0] mem_wdata,
    output logic [AW-1:0]        mem_raddr,
    input  logic [INSTR_LEN-1:0] mem_rdata,
    output logic [AW:0]          words_loaded,
    output logic                 load_err,
    output logic [2:0]           dbg_state
);

    // Load handshake: a byte transfers on any rising edge where ld_valid and
    // ld_ready are both high; ld_byte/ld_last are sampled on that same edge.
    // ld_ready depends only on the state, never on ld_valid.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIN  = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [AW:0] FULL_PTR = (AW+1)'(DEPTH);

    state_t                 state_q, state_d;
    logic [1:0]             byte_cnt_q;
    logic [AW:0]            wr_ptr_q;
    logic [AW:0]            words_q;
    logic [INSTR_LEN-9:0]   pack_q;
    logic                   mem_we_q;
    logic [AW-1:0]          mem_waddr_q;
    logic [INSTR_LEN-1:0]   mem_wdata_q;

    logic hs, last_byte, full, start, commit, err_hit, finish;
    logic [ADDR_LEN-3:0] pc_word;
    logic                in_range;
    logic                unused_pc_bits;

    always_comb begin
        hs        = ld_valid && (state_q == S_LOAD);
        last_byte = (byte_cnt_q == 2'd3);
        full      = (wr_ptr_q == FULL_PTR);
        // FIN is a one-cycle hand-off; a restart there is deliberately ignored.
        start     = boot_start && (state_q != S_FIN);
        commit    = hs && last_byte && !full && !start;
        err_hit   = hs && ((ld_last && !last_byte) || (last_byte && full));
        finish    = commit && ld_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (start)        state_d = S_LOAD;
                else if (err_hit) state_d = S_ERR;
                else if (finish)  state_d = S_FIN;
            end
            S_FIN:  state_d = S_RUN;
            S_RUN:  if (start) state_d = S_LOAD;
            S_ERR:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Packing and write datapath. The write of one word overlaps reception of
    // the next, so ld_ready never has to drop for a memory write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            words_q     <= '0;
            pack_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= commit;
            if (commit) begin
                mem_waddr_q <= wr_ptr_q[AW-1:0];
                mem_wdata_q <= {pack_q, ld_byte};
            end
            if (start) begin
                byte_cnt_q <= '0;
                wr_ptr_q   <= '0;
                words_q    <= '0;
            end else begin
                if (hs) begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    pack_q     <= {pack_q[INSTR_LEN-17:0], ld_byte};
                end
                if (commit)   wr_ptr_q <= wr_ptr_q + 1'b1;
                if (mem_we_q) words_q  <= words_q + 1'b1;
            end
        end
    end

    always_comb begin
        ld_ready     = (state_q == S_LOAD);
        cpu_run      = (state_q == S_RUN);
        load_err     = (state_q == S_ERR);
        dbg_state    = state_q;
        mem_we       = mem_we_q;
        mem_waddr    = mem_waddr_q;
        mem_wdata    = mem_wdata_q;
        words_loaded = words_q;
    end

    // Fetch gating: anything past the loaded program reads as NOP.
    always_comb begin
        mem_raddr      = cpu_pc[AW+1:2];
        pc_word        = cpu_pc[ADDR_LEN-1:2];
        in_range       = (pc_word < (ADDR_LEN-2)'(words_q));
        cpu_inst       = (cpu_run && in_range) ? mem_rdata : '0;
        unused_pc_bits = ^cpu_pc[1:0];
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: memory writes are checked by a scoreboard
// monitor; state/timing and fetch gating are checked directly by the sequence.
module tb_imem_boot_ctrl;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_FIN = 3'd2,
                           ST_RUN = 3'd3, ST_ERR = 3'd4;

    logic        clk, rst_n, boot_start, ld_valid, ld_ready, ld_last;
    logic [7:0]  ld_byte;
    logic [31:0] cpu_pc, cpu_inst, mem_wdata, mem_rdata;
    logic        cpu_run, mem_we, load_err;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [AW:0] words_loaded;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;
    logic [39:0] exp_q[$];
    logic [31:0] imem [DEPTH];

    imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW), .ADDR_LEN(32), .INSTR_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .boot_start(boot_start),
        .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last(ld_last),
        .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_run(cpu_run),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .words_loaded(words_loaded), .load_err(load_err), .dbg_state(dbg_state)
    );

    // Clock / reset / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) imem[i] = 32'hBAD0_0000 | i;
    end
    always @(posedge clk) if (mem_we) imem[mem_waddr] <= mem_wdata;
    assign mem_rdata = imem[mem_raddr];

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mem_we) begin
            n_writes++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write got addr=%0d data=%h, none expected",
                         mem_waddr, mem_wdata);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL mem_write got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_waddr, mem_wdata, e[39:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // Driver / check tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int w;
        w = 0;
        ld_valid = 1'b0;
        repeat (gap) sync();
        ld_byte  = b;
        ld_last  = last;
        ld_valid = 1'b1;
        @(negedge clk);
        while (!ld_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!ld_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ld_ready_timeout got 0 expected 1");
        end
        sync();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input int max_gap,
                             input bit exp_wr, input logic [7:0] addr);
        if (exp_wr) exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8], last && (i == 3),
                      (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic pulse_start();
        boot_start = 1'b1;
        sync();
        boot_start = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
        sync();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_load_err"}, load_err, 0);
        check({tag, "_mem_waddr"}, mem_waddr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_words_loaded"}, words_loaded, 0);
        check({tag, "_cpu_inst"}, cpu_inst, 0);
    endtask

    task automatic read_check(input string name, input logic [31:0] pc, input logic [31:0] exp);
        cpu_pc = pc;
        #1;
        check(name, cpu_inst, exp);
    endtask

    // Test sequence
    initial begin
        int wr0;
        rst_n = 1'b0; boot_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_byte = 8'h00; cpu_pc = 32'd4;
        sync();
        @(negedge clk);
        check_reset_outputs("rst_active");
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_after");

        // Gap-free two-word program
        sync();
        pulse_start();
        @(negedge clk);
        check("start_ld_ready", ld_ready, 1);
        check("start_state", dbg_state, ST_LOAD);
        sync();
        send_word(32'h01020304, 1'b0, 0, 1'b1, 8'd0);
        send_word(32'hAABBCCDD, 1'b1, 0, 1'b1, 8'd1);
        @(negedge clk);
        check("fin_state", dbg_state, ST_FIN);
        check("fin_mem_we", mem_we, 1);
        check("fin_ld_ready", ld_ready, 0);
        @(negedge clk);
        check("run_state", dbg_state, ST_RUN);
        check("run_cpu_run", cpu_run, 1);
        check("run_words", words_loaded, 2);
        drain();
        read_check("fetch_pc0", 32'd0, 32'h01020304);
        read_check("fetch_pc4", 32'd4, 32'hAABBCCDD);
        read_check("fetch_pc8_nop", 32'd8, 32'h0);
        read_check("fetch_pc5_unaligned", 32'd5, 32'hAABBCCDD);
        cpu_pc = 32'd4;
        sync();
        pulse_start();
        @(negedge clk);
        check("restart_cpu_run", cpu_run, 0);
        check("restart_ld_ready", ld_ready, 1);
        check("restart_words", words_loaded, 0);
        check("fetch_pc4_halted", cpu_inst, 0);

        // Three-word load with random valid gaps
        sync();
        wr0 = n_writes;
        send_word(32'h11223344, 1'b0, 3, 1'b1, 8'd0);
        send_word(32'h55667788, 1'b0, 3, 1'b1, 8'd1);
        send_word(32'h99AABBCC, 1'b1, 3, 1'b1, 8'd2);
        repeat (2) @(negedge clk);
        check("gap_run", cpu_run, 1);
        check("gap_words", words_loaded, 3);
        drain();
        check("gap_write_count", n_writes - wr0, 3);
        read_check("gap_pc0", 32'd0, 32'h11223344);
        read_check("gap_pc4", 32'd4, 32'h55667788);
        read_check("gap_pc8", 32'd8, 32'h99AABBCC);
        read_check("gap_pc12_nop", 32'd12, 32'h0);

        // ld_last on the 2nd byte of word 1
        pulse_start();
        send_word(32'hDEADBEEF, 1'b0, 0, 1'b1, 8'd0);
        send_byte(8'h5A, 1'b0, 0);
        send_byte(8'h5B, 1'b1, 0);
        @(negedge clk);
        check("err_state", dbg_state, ST_ERR);
        check("err_load_err", load_err, 1);
        check("err_mem_we", mem_we, 0);
        check("err_cpu_run", cpu_run, 0);
        check("err_ld_ready", ld_ready, 0);
        check("err_words", words_loaded, 1);
        drain();
        pulse_start();
        @(negedge clk);
        check("err_restart_state", dbg_state, ST_LOAD);
        check("err_restart_words", words_loaded, 0);
        check("err_restart_load_err", load_err, 0);

        // Overflow: 257 words
        sync();
        wr0 = n_writes;
        for (int i = 0; i <= DEPTH; i++)
            send_word(32'hC000_0000 | (i << 8) | (i ^ 8'h5C), 1'b0, 0, i < DEPTH, 8'(i));
        @(negedge clk);
        check("ovf_state", dbg_state, ST_ERR);
        check("ovf_load_err", load_err, 1);
        check("ovf_mem_we", mem_we, 0);
        check("ovf_words", words_loaded, 256);
        drain();
        check("ovf_write_count", n_writes - wr0, 256);

        // boot_start coincident with a 4th-byte handshake
        pulse_start();
        send_word(32'h0BADCAFE, 1'b0, 0, 1'b1, 8'd0);
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h56, 1'b0, 0);
        ld_byte = 8'h78; ld_last = 1'b1; ld_valid = 1'b1; boot_start = 1'b1;
        sync();
        ld_valid = 1'b0; ld_last = 1'b0; boot_start = 1'b0;
        @(negedge clk);
        check("coinc_mem_we", mem_we, 0);
        check("coinc_state", dbg_state, ST_LOAD);
        check("coinc_words", words_loaded, 0);
        sync();
        send_word(32'hCAFEF00D, 1'b1, 0, 1'b1, 8'd0);
        repeat (2) @(negedge clk);
        check("coinc_run", cpu_run, 1);
        check("coinc_words_final", words_loaded, 1);
        drain();
        read_check("coinc_pc0", 32'd0, 32'hCAFEF00D);
        read_check("coinc_pc4_nop", 32'd4, 32'h0);

        // Reset mid-load, with a write about to be launched
        pulse_start();
        wr0 = n_writes;
        send_byte(8'hA1, 1'b0, 0);
        send_byte(8'hA2, 1'b0, 0);
        send_byte(8'hA3, 1'b0, 0);
        ld_byte = 8'hA4; ld_valid = 1'b1; rst_n = 1'b0;
        sync();
        ld_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        sync();
        rst_n = 1'b1;
        repeat (3) sync();
        check("midrst_no_write", n_writes - wr0, 0);
        check("midrst_idle", dbg_state, ST_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
